pipe_controller: RTL and testbench

//  Pipelined ARM-subset control unit upstream of the datapath. Decodes InstrD[31:12] in Decode.

---
 rtl/pipe_controller.sv | 173 +++++++++++++++++
 tb/tb_pipe_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - ARM-subset pipelined control unit (optional PIPE_CTRL_NOWRITE_EN: CMP/TST skip Rd write)
module pipe_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemWriteM,
    output logic        MemtoRegE,
    output logic        MemtoRegW,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_w;
        logic       pc_src;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_ctl;
    } de_t;

    typedef struct packed {
        logic pc_src;
        logic reg_w;
        logic mem_w;
        logic mem_to_reg;
    } pipe_t;

    de_t        dec_d, de_d, de_q;
    pipe_t      em_d, em_q, mw_d, mw_q;
    logic [3:0] flags_d, flags_q;
    logic       cond_ex_e;

    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] cmd_d;
    logic [3:0] rd_d;
    logic       unused_instr;

    assign op_d         = InstrD[15:14];
    assign funct_d      = InstrD[13:8];
    assign cmd_d        = InstrD[12:9];
    assign rd_d         = InstrD[3:0];
    assign unused_instr = ^InstrD[7:4];

    always_comb begin
        dec_d      = '0;
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        dec_d.cond = InstrD[19:16];
        case (op_d)
            2'b00: begin
                dec_d.alu_src   = funct_d[5];
                dec_d.reg_w     = 1'b1;
`ifdef PIPE_CTRL_NOWRITE_EN
                if (cmd_d == 4'b1010 || cmd_d == 4'b1000)
                    dec_d.reg_w = 1'b0;
`endif
                dec_d.flag_w[1] = funct_d[0];
                dec_d.flag_w[0] = funct_d[0] &
                                  (cmd_d == 4'b0100 || cmd_d == 4'b0010 || cmd_d == 4'b1010);
                case (cmd_d)
                    4'b0100: dec_d.alu_ctl = 4'b0000;
                    4'b0010: dec_d.alu_ctl = 4'b0001;
                    4'b0000: dec_d.alu_ctl = 4'b0010;
                    4'b1100: dec_d.alu_ctl = 4'b0011;
                    4'b0001: dec_d.alu_ctl = 4'b0100;
                    4'b1101: dec_d.alu_ctl = 4'b0101;
                    4'b1010: dec_d.alu_ctl = 4'b0001;
                    4'b1000: dec_d.alu_ctl = 4'b0010;
                    default: dec_d.alu_ctl = 4'b0000;
                endcase
            end
            2'b01: begin
                dec_d.alu_src = 1'b1;
                dec_d.alu_ctl = funct_d[3] ? 4'b0000 : 4'b0001;
                if (funct_d[0]) begin
                    dec_d.reg_w      = 1'b1;
                    dec_d.mem_to_reg = 1'b1;
                end else begin
                    dec_d.mem_w = 1'b1;
                end
                ImmSrcD    = 2'b01;
                RegSrcD[1] = ~funct_d[0];
            end
            2'b10: begin
                dec_d.branch  = 1'b1;
                dec_d.alu_src = 1'b1;
                ImmSrcD       = 2'b10;
                RegSrcD[0]    = 1'b1;
            end
            default: ;
        endcase
        dec_d.pc_src = ((rd_d == 4'hF) & dec_d.reg_w) | dec_d.branch;
    end

    // Condition check uses the committed flags only; no bypass from the ALU.
    always_comb begin
        cond_ex_e = 1'b0;
        case (de_q.cond)
            4'b0000: cond_ex_e = flags_q[2];
            4'b0001: cond_ex_e = ~flags_q[2];
            4'b0010: cond_ex_e = flags_q[1];
            4'b0011: cond_ex_e = ~flags_q[1];
            4'b0100: cond_ex_e = flags_q[3];
            4'b0101: cond_ex_e = ~flags_q[3];
            4'b0110: cond_ex_e = flags_q[0];
            4'b0111: cond_ex_e = ~flags_q[0];
            4'b1000: cond_ex_e = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex_e = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_ex_e = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex_e = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex_e = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex_e = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    always_comb begin
        de_d = FlushE ? '0 : dec_d;

        em_d.pc_src     = de_q.pc_src & cond_ex_e;
        em_d.reg_w      = de_q.reg_w & cond_ex_e;
        em_d.mem_w      = de_q.mem_w & cond_ex_e;
        em_d.mem_to_reg = de_q.mem_to_reg;
        mw_d            = em_q;

        flags_d = flags_q;
        if (de_q.flag_w[1] & cond_ex_e)
            flags_d[3:2] = ALUFlags[3:2];
        if (de_q.flag_w[0] & cond_ex_e)
            flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            de_q    <= '0;
            em_q    <= '0;
            mw_q    <= '0;
            flags_q <= 4'b0000;
        end else begin
            de_q    <= de_d;
            em_q    <= em_d;
            mw_q    <= mw_d;
            flags_q <= flags_d;
        end
    end

    assign ALUSrcE      = de_q.alu_src;
    assign ALUControlE  = de_q.alu_ctl;
    assign MemtoRegE    = de_q.mem_to_reg;
    assign BranchTakenE = de_q.branch & cond_ex_e;
    assign MemWriteM    = em_q.mem_w;
    assign RegWriteM    = em_q.reg_w;
    assign RegWriteW    = mw_q.reg_w;
    assign MemtoRegW    = mw_q.mem_to_reg;
    assign PCSrcW       = mw_q.pc_src;
    assign PCWrPendingF = dec_d.pc_src | de_q.pc_src | em_q.pc_src;

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - randomized and directed bench for pipe_controller against a cycle-history model
module tb_pipe_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        ALUSrcE;
    logic [3:0]  ALUControlE;
    logic        BranchTakenE, MemWriteM, MemtoRegE, MemtoRegW;
    logic        RegWriteM, RegWriteW, PCSrcW, PCWrPendingF;

    always #5 clk = ~clk;

    pipe_controller dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .MemtoRegE(MemtoRegE),
        .MemtoRegW(MemtoRegW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
    );

    typedef struct {
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcsrc, regw, memw, memtoreg, branch, alusrc;
        logic [3:0] aluctl;
        logic [1:0] regsrc, immsrc;
    } ctl_t;

    localparam logic [19:0] NOP  = 20'hEC000;
    localparam logic [19:0] SUBS = 20'hE0500;
    localparam logic [19:0] BEQ  = 20'h0A000;
    localparam logic [19:0] BNE  = 20'h1A000;
    localparam logic [19:0] BCS  = 20'h2A000;
    localparam logic [19:0] LDR  = 20'hE5912;
    localparam logic [19:0] ADDR = 20'hE0821;
    localparam logic [19:0] CMPI = 20'hE3500;

    ctl_t       hist [0:2047];
    bit         ex_ok[0:2047];
    int         t = 0;
    int         last_rst = -1;
    logic [3:0] mflags = 4'b0000;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic ctl_t zero_ctl();
        ctl_t r;
        r.cond = 0; r.flagw = 0; r.pcsrc = 0; r.regw = 0; r.memw = 0; r.memtoreg = 0;
        r.branch = 0; r.alusrc = 0; r.aluctl = 0; r.regsrc = 0; r.immsrc = 0;
        return r;
    endfunction

    function automatic ctl_t decode(input logic [19:0] ins);
        ctl_t       r;
        logic [5:0] f;
        logic [3:0] cmd;
        r   = zero_ctl();
        f   = ins[13:8];
        cmd = f[4:1];
        r.cond = ins[19:16];
        if (ins[15:14] == 2'd0) begin
            r.alusrc = f[5];
            r.regw   = 1;
`ifdef PIPE_CTRL_NOWRITE_EN
            if (cmd == 4'hA || cmd == 4'h8) r.regw = 0;
`endif
            r.flagw = {f[0], f[0] & (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA)};
            if (cmd == 4'h4)      r.aluctl = 0;
            else if (cmd == 4'h2 || cmd == 4'hA) r.aluctl = 1;
            else if (cmd == 4'h0 || cmd == 4'h8) r.aluctl = 2;
            else if (cmd == 4'hC) r.aluctl = 3;
            else if (cmd == 4'h1) r.aluctl = 4;
            else if (cmd == 4'hD) r.aluctl = 5;
            else                  r.aluctl = 0;
        end else if (ins[15:14] == 2'd1) begin
            r.alusrc   = 1;
            r.aluctl   = f[3] ? 4'd0 : 4'd1;
            r.regw     = f[0];
            r.memtoreg = f[0];
            r.memw     = ~f[0];
            r.immsrc   = 2'b01;
            r.regsrc   = {~f[0], 1'b0};
        end else if (ins[15:14] == 2'd2) begin
            r.branch = 1;
            r.alusrc = 1;
            r.immsrc = 2'b10;
            r.regsrc = 2'b01;
        end
        r.pcsrc = ((ins[3:0] == 4'hF) && r.regw) || r.branch;
        return r;
    endfunction

    // Standard ARM trick: odd codes invert the even predicate; 1110/1111 are always/never.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v, base;
        {n, z, cy, v} = fl;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return !c[0];
        endcase
        return base ^ c[0];
    endfunction

    // Instruction decoded at cycle j survives to now only if no reset was taken at or after j.
    function automatic ctl_t live(input int j);
        if (j < 0 || last_rst >= j) return zero_ctl();
        return hist[j];
    endfunction

    task automatic step(input logic [19:0] ins, input logic [3:0] alf, input bit fl, input bit rs);
        ctl_t d, e, m, w;
        bit   ce, okm, okw;
        @(negedge clk);
        InstrD   = ins;
        ALUFlags = alf;
        FlushE   = fl;
        reset    = rs ? 1'b0 : 1'b1;
        #1;
        d   = decode(ins);
        e   = live(t - 1);
        m   = live(t - 2);
        w   = live(t - 3);
        ce  = cond_holds(e.cond, mflags);
        okm = (t >= 2) ? ex_ok[t-2] : 1'b0;
        okw = (t >= 3) ? ex_ok[t-3] : 1'b0;
        check("RegSrcD", RegSrcD, d.regsrc);
        check("ImmSrcD", ImmSrcD, d.immsrc);
        check("ALUSrcE", ALUSrcE, e.alusrc);
        check("ALUControlE", ALUControlE, e.aluctl);
        check("MemtoRegE", MemtoRegE, e.memtoreg);
        check("BranchTakenE", BranchTakenE, e.branch & ce);
        check("MemWriteM", MemWriteM, m.memw & okm);
        check("RegWriteM", RegWriteM, m.regw & okm);
        check("RegWriteW", RegWriteW, w.regw & okw);
        check("MemtoRegW", MemtoRegW, w.memtoreg);
        check("PCSrcW", PCSrcW, w.pcsrc & okw);
        check("PCWrPendingF", PCWrPendingF, d.pcsrc | e.pcsrc | (m.pcsrc & okm));
        if (t >= 1) ex_ok[t-1] = ce;
        hist[t] = fl ? zero_ctl() : d;
        if (rs) begin
            mflags   = 4'b0000;
            last_rst = t;
        end else if (ce) begin
            if (e.flagw[1]) mflags[3:2] = alf[3:2];
            if (e.flagw[0]) mflags[1:0] = alf[1:0];
        end
        t++;
    endtask

    initial begin
        logic [19:0] ri;
        reset    = 1'b0;
        InstrD   = 20'($urandom);
        ALUFlags = 4'($urandom);
        FlushE   = 1'b0;
        @(posedge clk);

        // Reset with arbitrary instruction, then pipeline must read empty
        step(20'($urandom), 4'hF, 1'b0, 1'b1);
        step(NOP, 4'h0, 1'b0, 0);
        check("rst_RegWriteW", RegWriteW, 0);
        check("rst_BranchTakenE", BranchTakenE, 0);

        // SUBS then BEQ: Z set in SUBS E cycle makes BEQ taken
        step(SUBS, 4'h0, 0, 0);
        step(BEQ, 4'b0100, 0, 0);
        step(NOP, 4'h0, 0, 0);
        check("beq_taken", BranchTakenE, 1);

        // Z=1, BNE not taken and never writes PC
        step(SUBS, 4'h0, 0, 0);
        step(BNE, 4'b0100, 0, 0);
        step(NOP, 4'h0, 0, 0);
        check("bne_not_taken", BranchTakenE, 0);
        step(NOP, 4'h0, 0, 0);
        step(NOP, 4'h0, 0, 0);
        check("bne_PCSrcW", PCSrcW, 0);

        // LDR through the pipe
        step(LDR, 4'h0, 0, 0);
        step(NOP, 4'h0, 0, 0);
        check("ldr_MemtoRegE", MemtoRegE, 1);
        step(NOP, 4'h0, 0, 0);
        check("ldr_MemWriteM", MemWriteM, 0);
        step(NOP, 4'h0, 0, 0);
        check("ldr_RegWriteW", RegWriteW, 1);
        check("ldr_MemtoRegW", MemtoRegW, 1);

        // ADD flushed into a bubble
        step(ADDR, 4'h0, 1, 0);
        step(NOP, 4'h0, 0, 0);
        step(NOP, 4'h0, 0, 0);
        check("flush_RegWriteM", RegWriteM, 0);
        step(NOP, 4'h0, 0, 0);
        check("flush_RegWriteW", RegWriteW, 0);

        // CMP writes all four flags: BCS then BEQ both taken
        step(NOP, 4'h0, 0, 1);
        step(CMPI, 4'h0, 0, 0);
        step(BCS, 4'b0110, 0, 0);
        step(BEQ, 4'h0, 0, 0);
        check("cmp_c_written", BranchTakenE, 1);
        step(NOP, 4'h0, 0, 0);
        check("cmp_z_written", BranchTakenE, 1);
`ifdef PIPE_CTRL_NOWRITE_EN
        check("cmp_RegWriteW", RegWriteW, 0);
`else
        check("cmp_RegWriteW", RegWriteW, 1);
`endif

        // Branch in E while FlushE bubbles the next instruction
        step(BEQ, 4'h0, 0, 0);
        step(ADDR, 4'h0, 1, 0);
        check("flush_branch_resolves", BranchTakenE, 1);

        for (int i = 0; i < 600; i++) begin
            ri = 20'($urandom);
            if ($urandom_range(0, 3) == 0) ri[3:0] = 4'hF;
            if ($urandom_range(0, 2) == 0) ri[19:16] = 4'hE;
            step(ri, 4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
